// File: rtl/ppl_stage_buf.sv
// Elastic pipeline stage buffer: DEPTH-entry circular queue with valid/ready handshake plus stall/flush.
// Optional performance counters are enabled with the PPL_STAGE_PERF_EN macro.
module ppl_stage_buf #(
  parameter int CTRL_W = 24,
  parameter int DATA_W = 129,
  parameter int DEPTH  = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         stall,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CTRL_W-1:0]            in_ctrl,
  input  logic [DATA_W-1:0]            in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CTRL_W-1:0]            out_ctrl,
  output logic [DATA_W-1:0]            out_data,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  output logic [31:0]                  perf_stall_cnt,
  output logic [31:0]                  perf_flush_cnt
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [CTRL_W-1:0] ctrl_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              push;
  logic              pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // Ready is derived only from local state so no combinational path runs from out_ready.
  assign full      = (count == DEPTH_C);
  assign in_ready  = !full && !stall && !flush;
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready && !stall && !flush;
  assign out_ctrl  = out_valid ? ctrl_mem[rd_ptr] : '0;
  assign out_data  = data_mem[rd_ptr];
  assign occupancy = count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (!stall) begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // The arrays survive flush; out_ctrl is masked by out_valid instead.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        ctrl_mem[i] <= '0;
        data_mem[i] <= '0;
      end
    end else if (push) begin
      ctrl_mem[wr_ptr] <= in_ctrl;
      data_mem[wr_ptr] <= in_data;
    end
  end

`ifdef PPL_STAGE_PERF_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
  logic [32:0] flush_sum;

  assign flush_sum = {1'b0, flush_cnt} + 33'(count) + 33'(in_valid);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (in_valid && !in_ready && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 32'd1;
      if (flush)
        flush_cnt <= flush_sum[32] ? '1 : flush_sum[31:0];
    end
  end

  assign perf_stall_cnt = stall_cnt;
  assign perf_flush_cnt = flush_cnt;
`else
  assign perf_stall_cnt = '0;
  assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_ppl_stage_buf.sv
// Bench for ppl_stage_buf: DEPTH=2 and DEPTH=3 instances share stimulus and are
// compared against a shift-queue reference model.
module tb_ppl_stage_buf;
  localparam int CW = 24;
  localparam int DW = 129;

  logic          clk = 1'b0;
  logic          rst;
  logic          stall;
  logic          flush;
  logic          in_valid;
  logic          out_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;

  logic          rdy [2];
  logic          ov  [2];
  logic [CW-1:0] oc  [2];
  logic [DW-1:0] od  [2];
  logic [1:0]    occ [2];
  logic [31:0]   psc [2];
  logic [31:0]   pfc [2];

  always #5 clk = ~clk;

  ppl_stage_buf #(.CTRL_W(CW), .DATA_W(DW), .DEPTH(2)) u_d2 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy[0]), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(ov[0]), .out_ready(out_ready), .out_ctrl(oc[0]), .out_data(od[0]),
    .occupancy(occ[0]), .perf_stall_cnt(psc[0]), .perf_flush_cnt(pfc[0])
  );

  ppl_stage_buf #(.CTRL_W(CW), .DATA_W(DW), .DEPTH(3)) u_d3 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy[1]), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(ov[1]), .out_ready(out_ready), .out_ctrl(oc[1]), .out_data(od[1]),
    .occupancy(occ[1]), .perf_stall_cnt(psc[1]), .perf_flush_cnt(pfc[1])
  );

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } ent_t;

  // Reference model: each buffer is an ordered list, head at index 0.
  ent_t        mq [2][8];
  int          mcnt [2];
  int unsigned mstall [2];
  int unsigned mflush [2];
  int          dep [2];
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] perf_exp(input int unsigned v);
    logic [31:0] r;
    r = '0;
`ifdef PPL_STAGE_PERF_EN
    r = v;
`endif
    return r;
  endfunction

  function automatic logic [DW-1:0] rand_data();
    return {$urandom, $urandom, $urandom, $urandom, 1'($urandom)};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mcnt[k]   = 0;
      mstall[k] = 0;
      mflush[k] = 0;
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      logic exp_rdy;
      exp_rdy = (mcnt[k] < dep[k]) && !stall && !flush;
      chk($sformatf("in_ready_d%0d", dep[k]), rdy[k], exp_rdy);
      chk($sformatf("out_valid_d%0d", dep[k]), ov[k], mcnt[k] != 0);
      chk($sformatf("out_ctrl_d%0d", dep[k]), oc[k], (mcnt[k] != 0) ? mq[k][0].c : '0);
      chk($sformatf("occupancy_d%0d", dep[k]), occ[k], mcnt[k]);
      if (mcnt[k] != 0)
        chk($sformatf("out_data_d%0d", dep[k]), od[k], mq[k][0].d);
      chk($sformatf("perf_stall_d%0d", dep[k]), psc[k], perf_exp(mstall[k]));
      chk($sformatf("perf_flush_d%0d", dep[k]), pfc[k], perf_exp(mflush[k]));
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      logic exp_rdy, do_push, do_pop;
      exp_rdy = (mcnt[k] < dep[k]) && !stall && !flush;
      if (in_valid && !exp_rdy) mstall[k]++;
      if (flush) begin
        mflush[k] += mcnt[k] + (in_valid ? 1 : 0);
        mcnt[k] = 0;
      end else if (!stall) begin
        do_push = in_valid && (mcnt[k] < dep[k]);
        do_pop  = (mcnt[k] != 0) && out_ready;
        if (do_pop) begin
          for (int i = 0; i < 7; i++) mq[k][i] = mq[k][i+1];
          mcnt[k]--;
        end
        if (do_push) begin
          mq[k][mcnt[k]] = '{c: in_ctrl, d: in_data};
          mcnt[k]++;
        end
      end
    end
  endtask

  // Called at a negedge: drive, check pre-edge view, advance model, cross one posedge.
  task automatic cycle(input logic iv, input logic [CW-1:0] c, input logic [DW-1:0] d,
                       input logic ordy, input logic st, input logic fl);
    in_valid  = iv;
    in_ctrl   = c;
    in_data   = d;
    out_ready = ordy;
    stall     = st;
    flush     = fl;
    #1;
    check_all();
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk({tag, "_in_ready"},  rdy[k], 1'b1);
      chk({tag, "_out_valid"}, ov[k],  1'b0);
      chk({tag, "_out_ctrl"},  oc[k],  '0);
      chk({tag, "_out_data"},  od[k],  '0);
      chk({tag, "_occupancy"}, occ[k], '0);
      chk({tag, "_perf_stall"}, psc[k], '0);
      chk({tag, "_perf_flush"}, pfc[k], '0);
    end
  endtask

  initial begin
    logic [DW-1:0] keep_d;
    dep[0] = 2;
    dep[1] = 3;
    rst = 1'b1; stall = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_ctrl = '0; in_data = '0;
    model_reset();
    #2;
    check_reset_outputs("por");
    @(negedge clk);
    rst = 1'b0;

    // Streaming at full rate with out_ready held high.
    for (int i = 0; i < 4; i++)
      cycle(1'b1, CW'(24'h0000A5 + i), DW'(16'h1234 + i), 1'b1, 1'b0, 1'b0);
    repeat (2) cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

    // Fill to full with out_ready low, then drain.
    cycle(1'b1, 24'h000011, DW'(32'h1111), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 24'h000022, DW'(32'h2222), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 24'h000033, DW'(32'h3333), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 24'h000033, DW'(32'h3333), 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 24'h000033, DW'(32'h3333), 1'b1, 1'b0, 1'b0);
    repeat (4) cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

    // Flush with push and stall asserted; payload at slot 0 must survive.
    cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    keep_d = rand_data();
    cycle(1'b1, 24'h0000C1, keep_d, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 24'h0000C2, rand_data(), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 24'h0000C3, rand_data(), 1'b0, 1'b1, 1'b1);
    #1;
    chk("flush_keeps_data_d2", od[0], keep_d);
    chk("flush_keeps_data_d3", od[1], keep_d);
    @(negedge clk);

    // Freeze for five stalled cycles at occupancy 1.
    cycle(1'b1, 24'h0000D1, rand_data(), 1'b0, 1'b0, 1'b0);
    repeat (5) cycle(1'b1, 24'h0000D2, rand_data(), 1'b1, 1'b1, 1'b0);
    repeat (3) cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

    // Randomized mixed traffic.
    for (int i = 0; i < 400; i++)
      cycle(($urandom_range(0, 9) < 7), CW'($urandom), rand_data(),
            ($urandom_range(0, 9) < 6), ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 19) == 0));

    // Asynchronous reset between edges with entries buffered.
    cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 24'h0000E1, rand_data(), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 24'h0000E2, rand_data(), 1'b0, 1'b0, 1'b0);
    in_valid = 1'b0;
    #1 rst = 1'b1;
    #1 check_reset_outputs("async_rst");
    model_reset();
    #1 rst = 1'b0;
    @(negedge clk);
    cycle(1'b1, 24'h0000F1, rand_data(), 1'b1, 1'b0, 1'b0);
    repeat (2) cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ppl_stage_buf.md
Name: ppl_stage_buf

Overview:
- Parametrised, elastic successor to the fixed ID/EX pipeline register. It sits between any two pipeline stages.
- Buffers up to DEPTH decoded-instruction entries behind a valid/ready handshake. Each entry holds a flushable control field and a non-flushable payload field.
- The legacy stall/flush controls are retained, so the hazard unit can drive this block directly.

Parameters:
- CTRL_W, 24: width of the control field (rd, rs1, rs2, alu op, jal/jalr/branch/bne, mem/reg enables, mul, prediction bit). Forced to zero on bubbles.
- DATA_W, 129: width of the payload field (rs1/rs2 data, imm, pc, compressed). Never zeroed by flush.
- DEPTH, 2: number of buffer entries, legal range 1..8. Non-power-of-2 values are allowed.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- stall  in  1  freeze: no push, no pop
- flush  in  1  discard every buffered entry and any push in the same cycle
- in_valid  in  1  upstream entry present
- in_ready  out  1  block accepts the entry this cycle
- in_ctrl  in  CTRL_W  control field of the incoming entry
- in_data  in  DATA_W  payload field of the incoming entry
- out_valid  out  1  head entry present
- out_ready  in  1  downstream consumes the head this cycle
- out_ctrl  out  CTRL_W  head control field; all zeros when out_valid=0
- out_data  out  DATA_W  head payload field, shown regardless of valid
- occupancy  out  $clog2(DEPTH+1)  current entry count
- perf_stall_cnt  out  32  upstream-blocked cycles (see Optional Feature)
- perf_flush_cnt  out  32  entries discarded by flush (see Optional Feature)

Behaviour:
- Storage: a circular array of DEPTH entries with rd_ptr, wr_ptr and count. Each pointer wraps from DEPTH-1 to 0.
- Handshake signals:
  - in_ready = (count < DEPTH) && !stall && !flush. It never depends on out_ready; there is no combinational ready path.
  - push = in_valid && in_ready.
  - pop = out_valid && out_ready && !stall && !flush.
- Latency: fixed 1 cycle. An entry pushed at edge N is visible on out_* after edge N. There is no bypass.
- Throughput: DEPTH>=2 sustains 1 entry/cycle. DEPTH=1 sustains at most 1 entry every 2 cycles; this is legal and documented.
- Output mux: out_valid = (count != 0). out_ctrl = out_valid ? ctrl[rd_ptr] : 0. out_data = data[rd_ptr] always.
- Per-edge priority, evaluated in this order:
  - rst: count=0, both pointers=0, all ctrl and data entries=0. This is asynchronous and takes effect mid-operation without waiting for a clock edge.
  - flush: count=0 and both pointers=0. Any push this cycle is dropped. The data array is untouched; the ctrl array may be left untouched because out_ctrl is gated by valid. Flush wins over stall.
  - stall: all state held and all outputs stable.
  - otherwise, push and pop act independently:
    - Push writes entry[wr_ptr] and advances wr_ptr.
    - Pop advances rd_ptr.
    - count += push - pop. Simultaneous push and pop at any occupancy leaves count unchanged.
- Boundaries:
  - Full (count==DEPTH): in_ready=0, and a pop in that cycle does not enable a same-cycle push.
  - Empty: out_valid=0 and out_ctrl=0. Asserting out_ready while empty has no effect.
  - in_valid dropping while in_ready=0 is permitted; no entry is lost because none was accepted.
- Reset values of every output:
  - in_ready=1
  - out_valid=0
  - out_ctrl=0
  - out_data=0
  - occupancy=0
  - perf_stall_cnt=0
  - perf_flush_cnt=0

Optional Feature:
- Macro: PPL_STAGE_PERF_EN.
- Defined:
  - perf_stall_cnt increments on every cycle where in_valid && !in_ready.
  - perf_flush_cnt adds count + (in_valid ? 1 : 0) on every flush cycle.
  - Both counters are 32-bit and saturate at 0xFFFFFFFF.
  - Both are cleared only by rst.
- Undefined: both ports are tied to 0 and no counter flops are synthesised.

Test Plan:
- DEPTH=2, out_ready=1, push in_ctrl=0x00_00A5 / in_data=0x1234 on edges 1..4 -> out_valid rises one cycle after each push; all four entries emerge in order at 1/cycle; occupancy never exceeds 1.
- DEPTH=2, out_ready=0, push 3 entries -> in_ready=0 after 2 pushes and occupancy=2. Raise out_ready -> entries 1 and 2 drain in order; entry 3 is accepted the cycle after count drops to 1.
- Occupancy 2, assert flush together with in_valid=1 and stall=1 -> next cycle occupancy=0, out_valid=0, out_ctrl=0, out_data unchanged. With PPL_STAGE_PERF_EN, perf_flush_cnt=3.
- Occupancy 1, stall=1 for 5 cycles with in_valid=1 and out_ready=1 -> all outputs frozen and no push or pop. With PPL_STAGE_PERF_EN, perf_stall_cnt=5.
- DEPTH=3, 10 mixed push/pop cycles driven by a scoreboard -> pointers wrap 2->0, output order matches the scoreboard, occupancy equals the model.
- Occupancy 2, assert rst between edges -> outputs take their reset values immediately without a clock edge. Deassert rst -> in_ready=1 on the first edge.
